// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode values and FSM state encoding.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bus of the sequential ALU: master is the operand source and result sink.
interface alu_seq_if #(
  parameter int WIDTH = 8
);

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its payload stable while valid is high and ready is low.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Bin;
  logic [2:0]       OPcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] ResultHi;
  logic             Cout;
  logic             Bout;
  logic             Zero;
  logic             Err;

  modport master (
    output in_valid, A, B, Cin, Bin, OPcode, out_ready,
    input  in_ready, out_valid, Result, ResultHi, Cout, Bout, Zero, Err
  );

  modport slave (
    input  in_valid, A, B, Cin, Bin, OPcode, out_ready,
    output in_ready, out_valid, Result, ResultHi, Cout, Bout, Zero, Err
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  // The final step's sum is exposed directly so the product lands on the edge the counter hits 0.
  assign o_done     = (r_cnt == CW'(1));
  assign o_product  = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_acc    <= '0;
      r_mplier <= i_b;
      r_cnt    <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arithmetic ops, iterative MUL, registered result and flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_seq_if.slave bus,
  output state_t o_state
);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_start_mul;
  logic               w_load_single;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_cout;
  logic               w_bout;
  logic               w_err;

  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_cout;
  logic               r_bout;
  logic               r_zero;
  logic               r_err;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start_mul),
    .i_a       (bus.A),
    .i_b       (bus.B),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // The extra top bit of the difference is the borrow: it is set exactly when A < B + Bin.
  assign w_sum  = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin};
  assign w_diff = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, bus.Bin};

  always_comb begin
    w_alu_res = '0;
    w_cout    = 1'b0;
    w_bout    = 1'b0;
    w_err     = 1'b0;
    case (bus.OPcode)
      OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_cout    = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_bout    = w_diff[WIDTH];
      end
      OP_AND:  w_alu_res = bus.A & bus.B;
      OP_OR:   w_alu_res = bus.A | bus.B;
      OP_XOR:  w_alu_res = bus.A ^ bus.B;
      OP_MUL:  w_alu_res = '0;
      default: w_err     = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_start_mul   = 1'b0;
    w_load_single = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.OPcode == OP_MUL) begin
            w_start_mul  = 1'b1;
            w_state_next = BUSY;
          end else begin
            w_load_single = 1'b1;
            w_state_next  = DONE;
          end
        end
      end
      BUSY:    if (w_mul_done)    w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_cout      <= 1'b0;
      r_bout      <= 1'b0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_load_single) begin
      r_result    <= w_alu_res;
      r_result_hi <= '0;
      r_cout      <= w_cout;
      r_bout      <= w_bout;
      r_zero      <= (w_alu_res == '0);
      r_err       <= w_err;
    end else if (r_state == BUSY && w_mul_done) begin
      r_result    <= w_product[WIDTH-1:0];
      r_result_hi <= w_product[2*WIDTH-1:WIDTH];
      r_cout      <= 1'b0;
      r_bout      <= 1'b0;
      r_zero      <= (w_product == '0);
      r_err       <= 1'b0;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.Result    = r_result;
  assign bus.ResultHi  = r_result_hi;
  assign bus.Cout      = r_cout;
  assign bus.Bout      = r_bout;
  assign bus.Zero      = r_zero;
  assign bus.Err       = r_err;
  assign o_state       = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios plus random ops checked against an arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W  = 8;
  localparam int EW = 2 * W + 4;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     n_pass;
  int     n_total;
  logic [EW-1:0] exp_q[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // Reference: {ResultHi, Result, Cout, Bout, Zero, Err} from plain integer arithmetic.
  function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin, input logic bin);
    longint m  = longint'(1) << W;
    longint lo = 0;
    longint hi = 0;
    longint s;
    logic   c  = 1'b0;
    logic   bo = 1'b0;
    logic   e  = 1'b0;
    case (op)
      3'd0: begin s = longint'(a) + longint'(b) + longint'(cin); lo = s % m; c = (s >= m); end
      3'd1: begin s = longint'(a) - longint'(b) - longint'(bin); bo = (s < 0); lo = (s + m) % m; end
      3'd2: lo = longint'(a & b);
      3'd3: lo = longint'(a | b);
      3'd4: lo = longint'(a ^ b);
      3'd5: begin s = longint'(a) * longint'(b); lo = s % m; hi = s / m; end
      default: e = 1'b1;
    endcase
    return {W'(hi), W'(lo), c, bo, (hi == 0 && lo == 0), e};
  endfunction

  function automatic logic [EW-1:0] obs();
    return {bus.ResultHi, bus.Result, bus.Cout, bus.Bout, bus.Zero, bus.Err};
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic scramble_inputs();
    bus.A      = W'($urandom);
    bus.B      = W'($urandom);
    bus.OPcode = 3'($urandom);
    bus.Cin    = 1'($urandom);
    bus.Bin    = 1'($urandom);
  endtask

  // One full transaction; bp > 0 holds out_ready low for bp cycles while noise is offered.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic bin, input int bp);
    int            lat;
    logic [EW-1:0] held;
    logic [EW-1:0] exp_v;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.OPcode    = op;
    bus.A         = a;
    bus.B         = b;
    bus.Cin       = cin;
    bus.Bin       = bin;
    bus.out_ready = (bp == 0);
    exp_q.push_back(model(op, a, b, cin, bin));
    check("in_ready_idle", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble_inputs();
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, (op == OP_MUL) ? W + 1 : 1);
    exp_v = exp_q.pop_front();
    held  = obs();
    check("result", held, exp_v);
    if (bp > 0) begin
      repeat (bp) begin
        bus.in_valid = 1'b1;
        scramble_inputs();
        @(negedge clk);
        check("bp_hold", obs(), held);
        check("bp_handshake", {bus.out_valid, bus.in_ready}, 2'b10);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    check("released", {bus.out_valid, bus.in_ready}, 2'b01);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic bad;
    n_pass        = 0;
    n_total       = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;
    bus.Bin       = 1'b0;
    bus.OPcode    = 3'b000;

    repeat (2) @(negedge clk);
    check("reset_outputs", obs(), '0);
    check("reset_handshake", {bus.out_valid, bus.in_ready}, 2'b01);
    rst_n = 1'b1;

    run_op(OP_ADD, 8'hF0, 8'h20, 1'b1, 1'b0, 0);
    run_op(OP_SUB, 8'h05, 8'h05, 1'b0, 1'b1, 0);
    run_op(OP_SUB, 8'h05, 8'h05, 1'b0, 1'b0, 0);
    run_op(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0, 0);
    check("mul_ff_ff_const", {bus.ResultHi, bus.Result}, 16'hFE01);

    // MUL interrupted by reset in its fourth BUSY cycle.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.OPcode    = OP_MUL;
    bus.A         = 8'hFF;
    bus.B         = 8'hFF;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mul_busy_handshake", {bus.out_valid, bus.in_ready}, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", obs(), '0);
    check("mid_reset_handshake", {bus.out_valid, bus.in_ready}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    bad   = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad = 1'b1;
    end
    check("no_late_valid", bad, 0);
    bus.out_ready = 1'b0;

    run_op(OP_XOR, 8'hAA, 8'hAA, 1'b0, 1'b0, 5);
    run_op(3'b110, 8'h12, 8'h34, 1'b1, 1'b1, 0);
    run_op(3'b111, 8'h00, 8'h00, 1'b0, 1'b0, 1);
    run_op(OP_AND, 8'hC3, 8'h5A, 1'b0, 1'b0, 0);
    run_op(OP_OR,  8'h00, 8'h00, 1'b1, 1'b0, 0);
    run_op(OP_MUL, 8'h00, 8'h7B, 1'b0, 1'b0, 2);
    run_op(OP_SUB, 8'h00, 8'hFF, 1'b0, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
